// File: rtl/csr_wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_wb_unit
// Description : Machine-mode CSR file and trap/return controller sitting at
//               the write-back end of the pipeline. Retires Zicsr accesses,
//               executes mret, samples external/timer interrupts and takes
//               them at the WB boundary, holding a redirect request to fetch
//               until fetch acknowledges it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   clock, all state updates on rising edge
//   clr           in   synchronous active-high reset
//   wb_valid      in   WB stage holds a real instruction
//   wb_csr_en     in   WB instruction is a CSR access
//   wfunc3        in   Zicsr func3 of the WB instruction
//   wb_csr_addr   in   CSR address of the WB instruction
//   csr_wdata_wb  in   write operand (rs1 or zero-extended zimm)
//   is_mret_wb    in   WB instruction is mret
//   int_pc        in   PC of the oldest unretired instruction
//   ext_irq       in   machine external interrupt (level)
//   timer_irq     in   machine timer interrupt (level)
//   csr_raddr     in   read address from decode
//   csr_rdata     out  read data, bypassed from the WB write
//   trap_req      out  redirect to trap handler, held until acked
//   trap_pc       out  registered handler address
//   redirect_ack  in   fetch has accepted trap_pc
//   mret_req      out  redirect to mepc (combinational)
//   mret_pc       out  current mepc
//   mie_glob      out  mstatus.MIE
// ============================================================================
module csr_wb_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wb_valid,
  input  logic        wb_csr_en,
  input  logic [2:0]  wfunc3,
  input  logic [11:0] wb_csr_addr,
  input  logic [31:0] csr_wdata_wb,
  input  logic        is_mret_wb,
  input  logic [31:0] int_pc,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        trap_req,
  output logic [31:0] trap_pc,
  input  logic        redirect_ack,
  output logic        mret_req,
  output logic [31:0] mret_pc,
  output logic        mie_glob
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [3:0] CODE_MTI = 4'd7;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]  state_q,        state_d;
  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_mtie_q,     mie_mtie_d;
  logic        mie_meie_q,     mie_meie_d;
  logic [31:0] mtvec_q,        mtvec_d;
  logic [31:0] mscratch_q,     mscratch_d;
  logic [31:0] mepc_q,         mepc_d;
  logic [31:0] mcause_q,       mcause_d;
  logic        mip_mtip_q,     mip_mtip_d;
  logic        mip_meip_q,     mip_meip_d;
  logic        trap_req_q,     trap_req_d;
  logic [31:0] trap_pc_q,      trap_pc_d;

  // --------------------------------------------------------------------------
  // Architectural views of the sparse registers
  // --------------------------------------------------------------------------
  logic [31:0] w_mstatus;
  logic [31:0] w_mie;
  logic [31:0] w_mip;

  // MPP is hardwired to machine mode.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign w_mie     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
  assign w_mip     = {20'b0, mip_meip_q, 3'b0, mip_mtip_q, 7'b0};

  logic w_run;
  assign w_run = (state_q == ST_RUN);

  // --------------------------------------------------------------------------
  // Register read for the WB write (old value) and the decode read port
  // --------------------------------------------------------------------------
  logic [31:0] w_old;
  logic [31:0] w_rd_reg;

  always_comb begin
    w_old = 32'h0;
    case (wb_csr_addr)
      ADDR_MSTATUS:  w_old = w_mstatus;
      ADDR_MIE:      w_old = w_mie;
      ADDR_MTVEC:    w_old = mtvec_q;
      ADDR_MSCRATCH: w_old = mscratch_q;
      ADDR_MEPC:     w_old = mepc_q;
      ADDR_MCAUSE:   w_old = mcause_q;
      ADDR_MIP:      w_old = w_mip;
      default:       w_old = 32'h0;
    endcase
  end

  always_comb begin
    w_rd_reg = 32'h0;
    case (csr_raddr)
      ADDR_MSTATUS:  w_rd_reg = w_mstatus;
      ADDR_MIE:      w_rd_reg = w_mie;
      ADDR_MTVEC:    w_rd_reg = mtvec_q;
      ADDR_MSCRATCH: w_rd_reg = mscratch_q;
      ADDR_MEPC:     w_rd_reg = mepc_q;
      ADDR_MCAUSE:   w_rd_reg = mcause_q;
      ADDR_MIP:      w_rd_reg = w_mip;
      default:       w_rd_reg = 32'h0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Zicsr write value
  // --------------------------------------------------------------------------
  logic [31:0] w_new;
  logic [31:0] w_new_legal;
  logic        w_f3_writes;
  logic        w_wr_en;

  always_comb begin
    w_new = w_old;
    case (wfunc3)
      3'b001, 3'b101: w_new = csr_wdata_wb;
      3'b010, 3'b110: w_new = w_old | csr_wdata_wb;
      3'b011, 3'b111: w_new = w_old & ~csr_wdata_wb;
      default:        w_new = w_old;
    endcase
  end

  assign w_f3_writes = (wfunc3 != 3'b000) && (wfunc3 != 3'b100);
  assign w_wr_en     = wb_csr_en & wb_valid & w_run & w_f3_writes;

  // Value the target register will actually hold after the write; the
  // bypass returns this so decode never sees bits the register drops.
  always_comb begin
    w_new_legal = 32'h0;
    case (wb_csr_addr)
      ADDR_MSTATUS:  w_new_legal = {19'b0, 2'b11, 3'b0, w_new[7], 3'b0, w_new[3], 3'b0};
      ADDR_MIE:      w_new_legal = {20'b0, w_new[11], 3'b0, w_new[7], 7'b0};
      ADDR_MTVEC:    w_new_legal = {w_new[31:2], 1'b0, w_new[0]};
      ADDR_MSCRATCH: w_new_legal = w_new;
      ADDR_MEPC:     w_new_legal = {w_new[31:2], 2'b00};
      ADDR_MCAUSE:   w_new_legal = w_new;
      ADDR_MIP:      w_new_legal = w_mip;
      default:       w_new_legal = 32'h0;
    endcase
  end

  assign csr_rdata = (w_wr_en && (wb_csr_addr == csr_raddr)) ? w_new_legal : w_rd_reg;

  // --------------------------------------------------------------------------
  // Interrupt take and mret qualification
  // --------------------------------------------------------------------------
  logic        w_pend_mei;
  logic        w_pend_mti;
  logic        w_take;
  logic [3:0]  w_code;
  logic [31:0] w_tvec_base;
  logic [31:0] w_trap_target;
  logic        w_mret;

  assign w_pend_mei = mip_meip_q & mie_meie_q;
  assign w_pend_mti = mip_mtip_q & mie_mtie_q;

  // CSR and mret instructions in WB defer the take by one cycle so their own
  // effects land first; evaluation uses the pre-write register values.
  assign w_take = w_run & mstatus_mie_q & wb_valid & (w_pend_mei | w_pend_mti)
                & ~wb_csr_en & ~is_mret_wb;

  assign w_code        = w_pend_mei ? CODE_MEI : CODE_MTI;
  assign w_tvec_base   = {mtvec_q[31:2], 2'b00};
  assign w_trap_target = mtvec_q[0] ? (w_tvec_base + {26'b0, w_code, 2'b00}) : w_tvec_base;

  assign w_mret   = is_mret_wb & wb_valid & w_run;
  assign mret_req = w_mret;
  assign mret_pc  = mepc_q;

  assign trap_req = trap_req_q;
  assign trap_pc  = trap_pc_q;
  assign mie_glob = mstatus_mie_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mip_mtip_d     = timer_irq;
    mip_meip_d     = ext_irq;
    trap_req_d     = trap_req_q;
    trap_pc_d      = trap_pc_q;

    if (w_take) begin
      mepc_d         = int_pc & ~32'd3;
      mcause_d       = {1'b1, 27'b0, w_code};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      trap_pc_d      = w_trap_target;
      trap_req_d     = 1'b1;
      state_d        = ST_TRAP;
    end else if (w_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (w_wr_en) begin
      case (wb_csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = w_new_legal[3];
          mstatus_mpie_d = w_new_legal[7];
        end
        ADDR_MIE: begin
          mie_mtie_d = w_new_legal[7];
          mie_meie_d = w_new_legal[11];
        end
        ADDR_MTVEC:    mtvec_d    = w_new_legal;
        ADDR_MSCRATCH: mscratch_d = w_new_legal;
        ADDR_MEPC:     mepc_d     = w_new_legal;
        ADDR_MCAUSE:   mcause_d   = w_new_legal;
        default: ;
      endcase
    end

    // Fetch accepted the redirect: resume normal retirement next cycle.
    if ((state_q == ST_TRAP) && redirect_ack) begin
      state_d    = ST_RUN;
      trap_req_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mip_mtip_q     <= 1'b0;
      mip_meip_q     <= 1'b0;
      trap_req_q     <= 1'b0;
      trap_pc_q      <= 32'h0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mip_mtip_q     <= mip_mtip_d;
      mip_meip_q     <= mip_meip_d;
      trap_req_q     <= trap_req_d;
      trap_pc_q      <= trap_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_wb_unit
// Description : Directed self-checking bench for csr_wb_unit. Inputs change
//               1 ns after the rising edge; outputs are compared on the
//               falling edge (or a few ns after the input change).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_wb_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        wb_valid;
  logic        wb_csr_en;
  logic [2:0]  wfunc3;
  logic [11:0] wb_csr_addr;
  logic [31:0] csr_wdata_wb;
  logic        is_mret_wb;
  logic [31:0] int_pc;
  logic        ext_irq;
  logic        timer_irq;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        redirect_ack;
  logic        mret_req;
  logic [31:0] mret_pc;
  logic        mie_glob;

  int n_checks = 0;
  int n_err    = 0;

  csr_wb_unit #(.MTVEC_RESET(32'h0000_0000)) dut (
    .clk          (clk),
    .clr          (clr),
    .wb_valid     (wb_valid),
    .wb_csr_en    (wb_csr_en),
    .wfunc3       (wfunc3),
    .wb_csr_addr  (wb_csr_addr),
    .csr_wdata_wb (csr_wdata_wb),
    .is_mret_wb   (is_mret_wb),
    .int_pc       (int_pc),
    .ext_irq      (ext_irq),
    .timer_irq    (timer_irq),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .trap_req     (trap_req),
    .trap_pc      (trap_pc),
    .redirect_ack (redirect_ack),
    .mret_req     (mret_req),
    .mret_pc      (mret_pc),
    .mie_glob     (mie_glob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csr_raddr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  // One CSR instruction in WB; checks the same-cycle bypass, returns 1 ns
  // after the commit edge with WB idle.
  task automatic csr_wr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] exp_byp, input string tag);
    wb_valid     = 1'b1;
    wb_csr_en    = 1'b1;
    wfunc3       = f3;
    wb_csr_addr  = a;
    csr_wdata_wb = d;
    csr_raddr    = a;
    @(negedge clk);
    check(tag, csr_rdata, exp_byp);
    tick();
    wb_valid  = 1'b0;
    wb_csr_en = 1'b0;
    wfunc3    = 3'b000;
  endtask

  initial begin
    clr = 1'b1; wb_valid = 1'b0; wb_csr_en = 1'b0; wfunc3 = 3'b000;
    wb_csr_addr = 12'h0; csr_wdata_wb = 32'h0; is_mret_wb = 1'b0;
    int_pc = 32'h0; ext_irq = 1'b0; timer_irq = 1'b0; csr_raddr = 12'h0;
    redirect_ack = 1'b0;
    tick();
    tick();
    clr = 1'b0;

    // Reset state
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h305, 32'h0000_0000, "rst_mtvec");
    rd(12'h344, 32'h0000_0000, "rst_mip");
    check("rst_trap_req", {31'b0, trap_req}, 32'd0);
    check("rst_trap_pc", trap_pc, 32'h0);
    check("rst_mie_glob", {31'b0, mie_glob}, 32'd0);
    check("rst_mret_req", {31'b0, mret_req}, 32'd0);
    tick();

    // Zicsr write/set/clear on mscratch
    csr_wr(3'b001, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "csrrw_byp");
    rd(12'h340, 32'hDEAD_BEEF, "csrrw_reg");
    csr_wr(3'b010, 12'h340, 32'h0000_0F00, 32'hDEAD_BFEF, "csrrs_byp");
    csr_wr(3'b111, 12'h340, 32'hFFFF_0000, 32'h0000_BFEF, "csrrc_byp");
    rd(12'h340, 32'h0000_BFEF, "csrrc_reg");

    // Non-writing func3 leaves the register alone
    csr_wr(3'b000, 12'h340, 32'h1111_1111, 32'h0000_BFEF, "f3_000_byp");

    // Unimplemented address
    csr_wr(3'b001, 12'h7C0, 32'h1234_5678, 32'h0, "unimpl_byp");
    rd(12'h7C0, 32'h0, "unimpl_reg");
    rd(12'h340, 32'h0000_BFEF, "unimpl_side_mscratch");
    rd(12'h300, 32'h0000_1800, "unimpl_side_mstatus");

    // Trap setup with field legalization
    csr_wr(3'b001, 12'h305, 32'h0000_1003, 32'h0000_1001, "mtvec_byp");
    csr_wr(3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0000_0880, "mie_byp");
    csr_wr(3'b001, 12'h341, 32'h0000_0123, 32'h0000_0120, "mepc_byp");
    csr_wr(3'b010, 12'h300, 32'h0000_0008, 32'h0000_1808, "mstatus_set_byp");
    check("mie_glob_set", {31'b0, mie_glob}, 32'd1);

    // Interrupt: cycle 0 raise, edge 1 mip, edge 2 take
    wb_valid = 1'b1; int_pc = 32'h0000_0206; ext_irq = 1'b1; timer_irq = 1'b1;
    csr_raddr = 12'h344;
    @(negedge clk);
    check("irq_c0_mip", csr_rdata, 32'h0);
    check("irq_c0_trap_req", {31'b0, trap_req}, 32'd0);
    tick();
    @(negedge clk);
    check("irq_c1_mip", csr_rdata, 32'h0000_0880);
    check("irq_c1_trap_req", {31'b0, trap_req}, 32'd0);
    tick();
    check("take_trap_req", {31'b0, trap_req}, 32'd1);
    check("take_trap_pc", trap_pc, 32'h0000_102C);
    check("take_mie_glob", {31'b0, mie_glob}, 32'd0);
    rd(12'h342, 32'h8000_000B, "take_mcause");
    rd(12'h341, 32'h0000_0204, "take_mepc");
    rd(12'h300, 32'h0000_1880, "take_mstatus");
    tick();
    check("hold_trap_req", {31'b0, trap_req}, 32'd1);
    redirect_ack = 1'b1;
    @(negedge clk);
    check("ack_cycle_trap_req", {31'b0, trap_req}, 32'd1);
    tick();
    redirect_ack = 1'b0;
    check("after_ack_trap_req", {31'b0, trap_req}, 32'd0);
    tick();
    check("no_retake_mie0", {31'b0, trap_req}, 32'd0);

    // mret: unqualified first, then qualified
    wb_valid = 1'b0; is_mret_wb = 1'b1;
    #1;
    check("mret_invalid_req", {31'b0, mret_req}, 32'd0);
    wb_valid = 1'b1;
    @(negedge clk);
    check("mret_req", {31'b0, mret_req}, 32'd1);
    check("mret_pc", mret_pc, 32'h0000_0204);
    tick();
    is_mret_wb = 1'b0;
    check("mret_mie_restored", {31'b0, mie_glob}, 32'd1);
    check("mret_no_take_yet", {31'b0, trap_req}, 32'd0);
    tick();
    check("retake_trap_req", {31'b0, trap_req}, 32'd1);
    check("retake_trap_pc", trap_pc, 32'h0000_102C);
    // Ack on the first TRAP cycle: TRAP lasts one cycle
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    check("fast_ack_trap_req", {31'b0, trap_req}, 32'd0);
    rd(12'h300, 32'h0000_1880, "retake_mstatus");

    // Pending interrupt while a CSRRW clears MIE
    csr_wr(3'b010, 12'h300, 32'h0000_0008, 32'h0000_1888, "mie_reset_byp");
    csr_wr(3'b001, 12'h300, 32'h0000_0000, 32'h0000_1800, "mie_clr_byp");
    wb_valid = 1'b1;
    check("clr_no_take_0", {31'b0, trap_req}, 32'd0);
    tick();
    check("clr_no_take_1", {31'b0, trap_req}, 32'd0);
    check("clr_mie_glob", {31'b0, mie_glob}, 32'd0);

    // Timer-only interrupt, vectored offset 4*7
    ext_irq = 1'b0;
    tick();
    csr_wr(3'b010, 12'h300, 32'h0000_0008, 32'h0000_1808, "mti_mie_set");
    wb_valid = 1'b1; int_pc = 32'h0000_0311;
    @(negedge clk);
    check("mti_pre_trap_req", {31'b0, trap_req}, 32'd0);
    tick();
    wb_valid = 1'b0;
    check("mti_trap_req", {31'b0, trap_req}, 32'd1);
    check("mti_trap_pc", trap_pc, 32'h0000_101C);
    rd(12'h342, 32'h8000_0007, "mti_mcause");
    rd(12'h341, 32'h0000_0310, "mti_mepc");

    // Reset in the middle of TRAP
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_trap_req", {31'b0, trap_req}, 32'd0);
    check("clr_trap_pc", trap_pc, 32'h0);
    rd(12'h300, 32'h0000_1800, "clr_mstatus");
    rd(12'h340, 32'h0, "clr_mscratch");
    tick();
    check("clr_stays_run", {31'b0, trap_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
